// File: rtl/hh_membrane_integrator.sv
// Hodgkin-Huxley membrane step: computes I_Na, I_K and I_L with one time-shared
// multiplier, then takes a forward-Euler step of V with saturation and spike detection.
module hh_membrane_integrator #(
    parameter int G_NA     = 120,
    parameter int G_K      = 36,
    parameter int G_L      = 77,
    parameter int E_NA     = 12800,
    parameter int E_K      = -19712,
    parameter int E_L      = -13926,
    parameter int DT_SHIFT = 5,
    parameter int V_TH     = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] v_in,
    input  logic        [15:0] m_in,
    input  logic        [15:0] h_in,
    input  logic        [15:0] n_in,
    input  logic signed [15:0] i_ext,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] v_next,
    output logic               spike,
    output logic        [15:0] spike_count
);

    typedef enum logic [3:0] {
        IDLE, M2, M3, MH, N2, N4, GNA, GK, INA, IK, IL, UPD, OUT
    } state_t;

    state_t state;

    logic signed [15:0] v_r, iext_r;
    logic        [15:0] m_r, h_r, n_r;
    logic        [15:0] m2_r, m3_r, mh_r, n2_r, n4_r;
    logic        [23:0] a_r, b_r;
    logic signed [24:0] ina_r, ik_r;
    logic signed [16:0] il_r;

    logic signed [16:0] diff_na, diff_k, diff_l;
    logic signed [24:0] mul_a;
    logic signed [17:0] mul_b;
    logic signed [40:0] product;

    logic signed [31:0] sum_i, dv, v_sum;
    logic signed [15:0] v_sat;
    logic               spike_now;

    assign diff_na = {v_r[15], v_r} - 17'(E_NA);
    assign diff_k  = {v_r[15], v_r} - 17'(E_K);
    assign diff_l  = {v_r[15], v_r} - 17'(E_L);

    // Operand selection for the shared multiplier; every operand fits a signed 25x18 product.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            M2:  begin mul_a = {9'b0, m_r};    mul_b = {2'b0, m_r};        end
            M3:  begin mul_a = {9'b0, m2_r};   mul_b = {2'b0, m_r};        end
            MH:  begin mul_a = {9'b0, m3_r};   mul_b = {2'b0, h_r};        end
            N2:  begin mul_a = {9'b0, n_r};    mul_b = {2'b0, n_r};        end
            N4:  begin mul_a = {9'b0, n2_r};   mul_b = {2'b0, n2_r};       end
            GNA: begin mul_a = {9'b0, mh_r};   mul_b = 18'(G_NA);          end
            GK:  begin mul_a = {9'b0, n4_r};   mul_b = 18'(G_K);           end
            INA: begin mul_a = {1'b0, a_r};    mul_b = {diff_na[16], diff_na}; end
            IK:  begin mul_a = {1'b0, b_r};    mul_b = {diff_k[16], diff_k};   end
            IL:  begin mul_a = 25'(G_L);       mul_b = {diff_l[16], diff_l};   end
            default: ;
        endcase
    end

    assign product = 41'(mul_a * mul_b);

    // Euler update in 32 bits so the current sum can never overflow before clamping.
    always_comb begin
        sum_i = 32'(iext_r) - (32'(ina_r) + 32'(ik_r) + 32'(il_r));
        dv    = sum_i >>> DT_SHIFT;
        v_sum = 32'(v_r) + dv;
        if (v_sum > 32'sd32767)
            v_sat = 16'sh7FFF;
        else if (v_sum < -32'sd32768)
            v_sat = 16'sh8000;
        else
            v_sat = v_sum[15:0];
        spike_now = (v_r < V_TH) && (v_sat >= V_TH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            v_next      <= '0;
            spike       <= 1'b0;
            spike_count <= '0;
            v_r  <= '0; iext_r <= '0; m_r <= '0; h_r <= '0; n_r <= '0;
            m2_r <= '0; m3_r <= '0; mh_r <= '0; n2_r <= '0; n4_r <= '0;
            a_r  <= '0; b_r <= '0; ina_r <= '0; ik_r <= '0; il_r <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    v_r      <= v_in;
                    m_r      <= m_in;
                    h_r      <= h_in;
                    n_r      <= n_in;
                    iext_r   <= i_ext;
                    in_ready <= 1'b0;
                    state    <= M2;
                end
                M2:  begin m2_r  <= product[31:16]; state <= M3;  end
                M3:  begin m3_r  <= product[31:16]; state <= MH;  end
                MH:  begin mh_r  <= product[31:16]; state <= N2;  end
                N2:  begin n2_r  <= product[31:16]; state <= N4;  end
                N4:  begin n4_r  <= product[31:16]; state <= GNA; end
                GNA: begin a_r   <= product[23:0];  state <= GK;  end
                GK:  begin b_r   <= product[23:0];  state <= INA; end
                INA: begin ina_r <= product[40:16]; state <= IK;  end
                IK:  begin ik_r  <= product[40:16]; state <= IL;  end
                IL:  begin il_r  <= product[24:8];  state <= UPD; end
                UPD: begin
                    v_next    <= v_sat;
                    spike     <= spike_now;
                    out_valid <= 1'b1;
                    if (spike_now && spike_count != 16'hFFFF)
                        spike_count <= spike_count + 16'd1;
                    state <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    spike     <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hh_membrane_integrator.sv
// Directed scoreboard bench for hh_membrane_integrator: an independent integer model
// predicts each result, which is queued on issue and compared when out_valid rises.
module tb_hh_membrane_integrator;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] v_in;
    logic        [15:0] m_in, h_in, n_in;
    logic signed [15:0] i_ext;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] v_next;
    logic               spike;
    logic        [15:0] spike_count;

    typedef struct {
        logic signed [15:0] v;
        logic               sp;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   fails   = 0;
    int   exp_count = 0;

    always #5 clk = ~clk;

    hh_membrane_integrator dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .v_in        (v_in),
        .m_in        (m_in),
        .h_in        (h_in),
        .n_in        (n_in),
        .i_ext       (i_ext),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .v_next      (v_next),
        .spike       (spike),
        .spike_count (spike_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Reference model written directly from the fixed-point equations in 64-bit arithmetic.
    function automatic exp_t model(input longint v, input longint m, input longint h,
                                   input longint n, input longint iext);
        longint m2, m3, mh, n2, n4, a, b, ina, ik, il, dvv, vn;
        exp_t r;
        m2  = (m * m) >> 16;
        m3  = (m2 * m) >> 16;
        mh  = (m3 * h) >> 16;
        n2  = (n * n) >> 16;
        n4  = (n2 * n2) >> 16;
        a   = 120 * mh;
        b   = 36 * n4;
        ina = (a * (v - 12800)) >>> 16;
        ik  = (b * (v + 19712)) >>> 16;
        il  = (77 * (v + 13926)) >>> 8;
        dvv = (iext - (ina + ik + il)) >>> 5;
        vn  = v + dvv;
        if (vn > 32767) vn = 32767;
        if (vn < -32768) vn = -32768;
        r.v  = 16'(vn);
        r.sp = (v < 0) && (vn >= 0);
        return r;
    endfunction

    task automatic applyStimulus(input int v, input int m, input int h, input int n, input int iext);
        check("in_ready_before_issue", 32'(in_ready), 32'd1);
        v_in = 16'(v); m_in = 16'(m); h_in = 16'(h); n_in = 16'(n); i_ext = 16'(iext);
        in_valid = 1'b1;
        sb.push_back(model(longint'(v), longint'(m), longint'(h), longint'(n), longint'(iext)));
        @(posedge clk); #1;
        in_valid = 1'b0;
        v_in  = 16'($urandom);
        m_in  = 16'($urandom);
        h_in  = 16'($urandom);
        n_in  = 16'($urandom);
        i_ext = 16'($urandom);
    endtask

    task automatic checkOutput(input int hold);
        int   lat;
        exp_t e;
        logic signed [15:0] held_v;
        logic               held_sp;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'd11);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
            e.v = '0; e.sp = 1'b0;
        end else begin
            e = sb.pop_front();
        end
        if (e.sp && exp_count < 65535) exp_count++;
        check("v_next", 32'(v_next), 32'(e.v));
        check("spike", 32'(spike), 32'(e.sp));
        check("spike_count", 32'(spike_count), 32'(exp_count));
        held_v  = v_next;
        held_sp = spike;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_v_next", 32'(v_next), 32'(e.v));
            check("hold_spike", 32'(spike), 32'(held_sp));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_out_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_spike", 32'(spike), 32'd0);
        check("post_v_next_kept", 32'(v_next), 32'(held_v));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        v_in = '0; m_in = '0; h_in = '0; n_in = '0; i_ext = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_v_next", 32'(v_next), 32'd0);
        check("reset_spike", 32'(spike), 32'd0);
        check("reset_spike_count", 32'(spike_count), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Leak equilibrium and stimulus step.
        applyStimulus(-13926, 0, 0, 0, 0);       checkOutput(0);
        applyStimulus(-13926, 0, 0, 0, 2560);    checkOutput(0);
        // Saturation at both rails.
        applyStimulus(-32768, 0, 0, 0, -32768);  checkOutput(0);
        applyStimulus(32767, 0, 0, 0, 32767);    checkOutput(0);
        // Threshold crossing and near miss.
        applyStimulus(-16, 0, 0, 0, 4823);       checkOutput(0);
        check("spike_count_after_cross", 32'(spike_count), 32'd1);
        applyStimulus(-16, 0, 0, 0, 4215);       checkOutput(0);
        // Active gating currents exercise every multiplier stage.
        applyStimulus(-16000, 16'h4000, 16'h9000, 16'h5000, 1000);  checkOutput(0);
        applyStimulus(8000, 16'hFFFF, 16'hFFFF, 16'hFFFF, -5000);   checkOutput(0);
        applyStimulus(-1200, 16'hC000, 16'h2000, 16'h8000, 20000);  checkOutput(0);
        // Backpressure.
        applyStimulus(-16, 0, 0, 0, 4823);       checkOutput(5);

        // Reset while the INA product is in progress.
        applyStimulus(-5000, 16'h7000, 16'h7000, 16'h7000, 3000);
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        exp_count = 0;
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_spike_count", 32'(spike_count), 32'd0);
        check("midreset_v_next", 32'(v_next), 32'd0);
        applyStimulus(-16, 0, 0, 0, 4823);       checkOutput(1);
        applyStimulus(-13926, 16'h3000, 16'hA000, 16'h6000, 2560); checkOutput(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
